// File: rtl/spi_target_if.sv
// SPI target bus bundle: serial pins plus the parallel tx/rx byte handshake.
// The slave modport is the target's view; master is the controller/host view.
interface spi_target_if;
  logic       i_sclk;
  logic       i_cs_n;
  logic       i_mosi;
  logic       o_miso;
  logic       o_miso_oe;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_busy;

  modport slave (
    input  i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
    output o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
    input  o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy
  );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, 8-bit frames, fully in the i_clk domain.
// SCLK/CS_N/MOSI are oversampled through synchronizers; edges come from a history flop.
module spi_target (
  input  logic         i_clk,
  input  logic         i_rst,
  spi_target_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [2:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [1:0]  fill_q, fill_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;

  logic        sync_ok_s;
  logic        sclk_rise_s;
  logic        sclk_fall_s;
  logic        cs_fall_s;
  logic        consume_s;
  logic        accept_s;
  logic [7:0]  reload_byte_s;

  // Synchronizer shifting, edge detection and the shared reload byte.
  always_comb begin
    sclk_sync_d   = {sclk_sync_q[1:0], bus.i_sclk};
    cs_sync_d     = {cs_sync_q[1:0], bus.i_cs_n};
    mosi_sync_d   = {mosi_sync_q[0], bus.i_mosi};
    // Edges are trusted only once every history stage holds a post-reset sample,
    // so a CS held low through reset is not mistaken for a fresh fall.
    sync_ok_s     = (fill_q == 2'd3);
    sclk_rise_s   = sync_ok_s & sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall_s   = sync_ok_s & ~sclk_sync_q[1] & sclk_sync_q[2];
    cs_fall_s     = sync_ok_s & ~cs_sync_q[1] & cs_sync_q[2];
    reload_byte_s = hold_full_q ? hold_q : 8'hFF;
    if (fill_q != 2'd3) begin
      fill_d = fill_q + 2'd1;
    end else begin
      fill_d = fill_q;
    end
  end

  // Frame FSM: bit counter, shift registers and received-byte strobe.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    consume_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 7'd0;
          tx_shift_d = reload_byte_s;
          consume_s  = hold_full_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_sync_q[1]) begin
          // Mid-byte deselect: partial rx and loaded tx byte are simply dropped.
          state_d    = ST_IDLE;
          bit_cnt_d  = 3'd0;
          tx_shift_d = 8'h00;
        end else if (sclk_rise_s) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_sync_q[1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q, mosi_sync_q[1]};
            rx_valid_d = 1'b1;
          end else begin
            rx_valid_d = 1'b0;
          end
        end else if (sclk_fall_s) begin
          if (bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end else begin
            tx_shift_d = reload_byte_s;
            consume_s  = hold_full_q;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Holding register: a consume on a full register wins; accepts only land when empty.
  always_comb begin
    accept_s    = bus.i_tx_valid & ~hold_full_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (consume_s) begin
      hold_full_d = 1'b0;
    end else if (accept_s) begin
      hold_d      = bus.i_tx_data;
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  // State and datapath registers with asynchronous reset to idle levels.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      fill_q      <= 2'd0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign bus.o_busy     = (state_q == ST_ACTIVE);
  assign bus.o_miso_oe  = (state_q == ST_ACTIVE);
  assign bus.o_miso     = (state_q == ST_ACTIVE) & tx_shift_q[7];
  assign bus.o_tx_ready = ~hold_full_q;
  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_rx_valid = rx_valid_q;

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have ports: i_clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: i_rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: i_sclk  in  1  SPI serial clock from controller, asynchronous to i_clk, idle low.
REQ-004 SHALL have ports: i_cs_n  in  1  chip select, active-low, asynchronous.
REQ-005 SHALL have ports: i_mosi  in  1  serial data in, asynchronous.
REQ-006 SHALL have ports: o_miso  out  1  serial data out; o_miso_oe  out  1  MISO output enable.
REQ-007 SHALL have ports: i_tx_data  in  8  next byte to send; i_tx_valid  in  1; o_tx_ready  out  1  holding register empty.
REQ-008 SHALL have ports: o_rx_data  out  8  last complete received byte; o_rx_valid  out  1  one-cycle strobe.
REQ-009 SHALL have ports: o_busy  out  1  target selected (synchronized CS active).

Function
REQ-010 SHALL implement SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit frames; sample MOSI on SCLK rise, change MISO on SCLK fall.
REQ-011 SHALL pass i_sclk, i_cs_n, i_mosi through 2-flop synchronizers and detect edges from a third history flop; no logic clocked by i_sclk.
REQ-012 SHALL operate correctly for SCLK high and low phases each >= 2 i_clk periods (divisor >= 4); divisor 2 is unsupported, behaviour undefined.
REQ-013 SHALL have two states: IDLE (sync CS high) and ACTIVE (sync CS low); IDLE->ACTIVE on sync CS fall, ACTIVE->IDLE on sync CS rise, from any bit position.
REQ-014 SHALL on IDLE->ACTIVE: clear 3-bit bit counter, load tx shift register from holding register if full (marking it empty), else 0xFF; set o_busy, o_miso_oe.
REQ-015 SHALL drive o_miso = tx_shift[7] while ACTIVE, 0 while IDLE; o_miso_oe = o_busy.
REQ-016 SHALL on each sync SCLK rise in ACTIVE: shift sync MOSI into rx shift LSB, increment bit counter (7 wraps to 0).
REQ-017 SHALL on the rise that wraps the counter to 0: o_rx_data <= assembled byte and o_rx_valid = 1 for exactly the next i_clk cycle; no backpressure, previous o_rx_data overwritten.
REQ-018 SHALL on each sync SCLK fall in ACTIVE: if counter != 0 shift tx register left by 1; if counter == 0 reload from holding register if full (mark empty), else 0xFF.
REQ-019 SHALL accept i_tx_data when i_tx_valid && o_tx_ready; o_tx_ready deasserts the following cycle and reasserts the cycle after the holding register is consumed.
REQ-020 SHALL, when accept and reload coincide on an empty holding register, reload 0xFF and keep the newly accepted byte for the next frame.
REQ-021 SHALL, on CS deassert mid-byte: discard partial rx byte, no o_rx_valid, drop tx shift contents (byte already loaded counts as consumed), retain holding register.
REQ-022 SHALL ignore SCLK edges and MOSI while IDLE; o_rx_data holds last value across IDLE.

Reset
REQ-023 SHALL on i_rst=1, immediately: state IDLE, o_miso=0, o_miso_oe=0, o_busy=0, o_tx_ready=1, o_rx_valid=0, o_rx_data=0x00, counter=0, holding register empty.
REQ-024 SHALL reset synchronizer flops to idle levels (SCLK 0, CS_N 1, MOSI 0) so no spurious edge is seen at reset release.
REQ-025 SHALL, if reset asserts mid-frame, abandon the frame; after release, wait for a fresh CS fall before shifting.

Verification
REQ-026 Single byte: preload 0xA5, CS low, SCLK period 4 i_clk, MOSI 0x3C -> MISO 1,0,1,0,0,1,0,1 at rises; one o_rx_valid pulse with o_rx_data=0x3C.
REQ-027 Underrun: no preload, transfer 0x81 -> MISO 0xFF, o_rx_data=0x81, o_tx_ready stays 1.
REQ-028 Back-to-back: preload 0x11, load 0x22 after first ready rise, 16 SCLKs no CS gap -> MISO 0x11 then 0x22, two o_rx_valid pulses.
REQ-029 Abort: CS high after 5 rises -> no o_rx_valid, o_busy=0 within 3 i_clk; next frame receives full correct byte from bit 7.
REQ-030 Handshake: i_tx_valid held with holding register full -> no overwrite; accepted byte appears on MISO only in next frame.
REQ-031 Reset mid-frame after 3 bits -> all outputs at REQ-023 values same cycle; following frame correct.
